fetch_pc_ctrl: RTL and testbench
================================

// Module: fetch_pc_ctrl
// PURPOSE
//   Fetch-side consumer of the branch decision (NextPCSrc) and the EX-stage branch/jump target.
//   Owns the architectural PC and issues instruction-memory requests, one outstanding at a time.
//   Delivers {pc, inst} to the IF/ID register and flushes wrong-path instructions on a taken branch.
//   Sits between the hazard unit and branch unit on one side, and IMEM and IF/ID on the other.
// PARAMETERS
//   RESET_PC  32'h0000_0000  PC of first fetch after reset
//   NOP_INST  32'h0000_0013  instruction driven on if_inst when no valid instruction (addi x0,x0,0)
// PORTS
//   clk            in   1   system clock, rising edge
//   rst_n          in   1   asynchronous active-low reset
//   NextPCSrc      in   1   branch unit: 1 = redirect to br_target this cycle
//   br_target      in   32  redirect target (EX-stage ALU result)
//   stall          in   1   hazard unit: hold IF/ID contents and PC
//   imem_req       out  1   request valid
//   imem_addr      out  32  request address, word aligned
//   imem_ready     in   1   IMEM accepts request this cycle
//   imem_rvalid    in   1   response data valid
//   imem_rdata     in   32  response instruction
//   if_valid       out  1   if_inst/if_pc hold a real instruction
//   if_pc          out  32  PC of if_inst
//   if_inst        out  32  instruction to IF/ID
//   flush_ifid     out  1   kill IF/ID contents (combinational = NextPCSrc)
//   flush_idex     out  1   kill ID/EX contents (combinational = NextPCSrc)
// BEHAVIOUR
//   Reset (async assert, sync release): pc=RESET_PC, state=BOOT, kill=0, imem_req=0,
//     if_valid=0, if_pc=0, if_inst=NOP_INST; flush_* follow NextPCSrc (0 when input low).
//   State machine: BOOT, REQ, WAIT, HOLD.
//   BOOT -> REQ unconditionally on the first edge after reset release.
//   REQ:  imem_req=1, imem_addr=pc. When imem_ready=1: -> WAIT. Otherwise stay in REQ.
//   WAIT: imem_req=0. Wait for imem_rvalid.
//     If kill=1: discard rdata, clear kill, -> REQ (pc already holds the target).
//     Else if stall=0: if_inst<=rdata, if_pc<=pc, if_valid<=1, pc<=pc+4, -> REQ.
//     Else: rdata into 1-entry skid buffer (buf_inst, buf_pc), -> HOLD.
//   HOLD: no request; when stall=0: IF/ID outputs <= buffer, if_valid<=1, pc<=pc+4, -> REQ.
//   stall=1: if_valid/if_pc/if_inst held unchanged, pc unchanged; requests in flight still complete.
//   When not stalled and no response is delivered that cycle, if_valid<=0 and if_inst<=NOP_INST.
//   Redirect (NextPCSrc=1) has priority over stall and over everything except reset:
//     pc <= {br_target[31:2],2'b00}; if_valid<=0 and if_inst<=NOP_INST on the same edge.
//     REQ, not accepted: -> REQ with the new address next cycle. imem_addr may change while
//       imem_req=1; IMEM tolerates this.
//     REQ, accepted the same cycle: set kill, -> WAIT.
//     WAIT, no rvalid: set kill, stay in WAIT.
//     WAIT with rvalid: drop rdata, -> REQ.
//     HOLD: drop buffer, -> REQ.
//     BOOT: pc<=target, -> REQ.
//   At most one request outstanding; imem_rvalid outside WAIT is ignored.
//   PC arithmetic: 32-bit, pc+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000; imem_addr[1:0] always 0.
//   Back-to-back redirects: the last target wins; kill stays set until one response is dropped.
//   Reset mid-request: state is abandoned; a late imem_rvalid after reset is ignored (state != WAIT).
// TESTING
//   1) Reset release, ready=1, rvalid 1 cycle after accept, rdata=0xA
//      -> imem_addr=0,4,8...; if_pc=0,4 with if_valid pulses; reset values checked before release.
//   2) stall=1 while rvalid for pc=0x8
//      -> HOLD; if_* unchanged; stall=0 -> if_pc=0x8, if_inst=buffered data, next imem_addr=0xC.
//   3) NextPCSrc=1, br_target=0x103 while in WAIT for pc=0x10
//      -> flush_*=1 that cycle; response dropped; next imem_addr=0x100; if_valid=0 until 0x100 returns.
//   4) NextPCSrc and stall both 1 in HOLD
//      -> buffer dropped; imem_addr=target next cycle; if_valid=0.
//   5) pc=0xFFFF_FFFC fetched -> next imem_addr=0x0000_0000.
//   6) rst_n low while in WAIT, rvalid arrives 1 cycle after release
//      -> ignored; first delivered if_pc=RESET_PC.

Source files
------------

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC controller: owns the architectural PC, issues one IMEM request at a time, feeds IF/ID.
// Latency: two cycles per instruction (REQ accept, then WAIT for the response) at best.
// Backpressure: stall holds IF/ID and PC; a response that arrives under stall parks in a 1-entry skid buffer.
//
// Ports:
//   clk, rst_n                      clock / async active-low reset
//   NextPCSrc, br_target            redirect request and target from the branch unit
//   stall                           hazard-unit hold of IF/ID and PC
//   imem_req/addr/ready             request channel (one outstanding)
//   imem_rvalid/rdata               response channel
//   if_valid, if_pc, if_inst        instruction delivered to IF/ID
//   flush_ifid, flush_idex          wrong-path kill, combinational copy of NextPCSrc
module fetch_pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        NextPCSrc,
  input  logic [31:0] br_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        flush_ifid,
  output logic        flush_idex
);

  typedef enum logic [1:0] {S_BOOT, S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic        kill, kill_nxt;
  logic [31:0] buf_inst, buf_inst_nxt;
  logic [31:0] buf_pc, buf_pc_nxt;
  logic        if_valid_nxt;
  logic [31:0] if_pc_nxt, if_inst_nxt;
  logic        deliver;
  logic [31:0] dlv_pc, dlv_inst;
  logic [31:0] redir_pc;
  logic        unused_tgt_lsbs;

  // Targets are forced to word alignment; the low bits carry no information here.
  assign redir_pc        = {br_target[31:2], 2'b00};
  assign unused_tgt_lsbs = ^br_target[1:0];

  assign imem_addr  = pc;
  assign flush_ifid = NextPCSrc;
  assign flush_idex = NextPCSrc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    kill_nxt     = kill;
    buf_inst_nxt = buf_inst;
    buf_pc_nxt   = buf_pc;
    imem_req     = 1'b0;
    deliver      = 1'b0;
    dlv_pc       = pc;
    dlv_inst     = imem_rdata;

    case (state)
      S_BOOT: begin
        state_nxt = S_REQ;
        if (NextPCSrc) pc_nxt = redir_pc;
      end
      S_REQ: begin
        imem_req = 1'b1;
        if (NextPCSrc) pc_nxt = redir_pc;
        if (imem_ready) begin
          state_nxt = S_WAIT;
          // The request just accepted is for the old path; its response must be dropped.
          if (NextPCSrc) kill_nxt = 1'b1;
        end
      end
      S_WAIT: begin
        if (NextPCSrc) begin
          pc_nxt = redir_pc;
          if (imem_rvalid) begin
            kill_nxt  = 1'b0;
            state_nxt = S_REQ;
          end else begin
            kill_nxt = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (kill) begin
            // pc already holds the redirect target.
            kill_nxt  = 1'b0;
            state_nxt = S_REQ;
          end else if (!stall) begin
            deliver   = 1'b1;
            dlv_pc    = pc;
            dlv_inst  = imem_rdata;
            pc_nxt    = pc + 32'd4;
            state_nxt = S_REQ;
          end else begin
            buf_inst_nxt = imem_rdata;
            buf_pc_nxt   = pc;
            state_nxt    = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (NextPCSrc) begin
          pc_nxt    = redir_pc;
          state_nxt = S_REQ;
        end else if (!stall) begin
          deliver   = 1'b1;
          dlv_pc    = buf_pc;
          dlv_inst  = buf_inst;
          pc_nxt    = pc + 32'd4;
          state_nxt = S_REQ;
        end
      end
      default: state_nxt = S_BOOT;
    endcase

    // IF/ID update: redirect kills, stall holds, otherwise a bubble unless something is delivered.
    if_valid_nxt = if_valid;
    if_pc_nxt    = if_pc;
    if_inst_nxt  = if_inst;
    if (NextPCSrc) begin
      if_valid_nxt = 1'b0;
      if_inst_nxt  = NOP_INST;
    end else if (deliver) begin
      if_valid_nxt = 1'b1;
      if_pc_nxt    = dlv_pc;
      if_inst_nxt  = dlv_inst;
    end else if (!stall) begin
      if_valid_nxt = 1'b0;
      if_inst_nxt  = NOP_INST;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      kill     <= 1'b0;
      buf_inst <= NOP_INST;
      buf_pc   <= 32'h0;
      if_valid <= 1'b0;
      if_pc    <= 32'h0;
      if_inst  <= NOP_INST;
    end else begin
      pc       <= pc_nxt;
      kill     <= kill_nxt;
      buf_inst <= buf_inst_nxt;
      buf_pc   <= buf_pc_nxt;
      if_valid <= if_valid_nxt;
      if_pc    <= if_pc_nxt;
      if_inst  <= if_inst_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Bench for fetch_pc_ctrl: cycle-driven scenarios with a behavioural IMEM and a delivery scoreboard.
module tb_fetch_pc_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        NextPCSrc;
  logic [31:0] br_target;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        flush_ifid;
  logic        flush_idex;

  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t sb[$];

  // IMEM model state: single pending response, returned lat cycles after acceptance.
  int          lat = 1;
  bit          pend = 0;
  int          pcnt = 0;
  logic [31:0] paddr = 32'h0;

  fetch_pc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .NextPCSrc(NextPCSrc), .br_target(br_target), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a + 32'h0000_000A;
  endfunction

  function automatic exp_t mk(input logic [31:0] a);
    exp_t e;
    e.pc   = a;
    e.inst = inst_of(a);
    return e;
  endfunction

  // Advance one clock; afterwards drive the IMEM response channel.
  task automatic tick();
    logic        acc;
    logic [31:0] aa;
    acc = imem_req && imem_ready;
    aa  = imem_addr;
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    if (acc) begin
      pend  = 1;
      pcnt  = lat;
      paddr = aa;
    end
    if (pend) begin
      pcnt--;
      if (pcnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = inst_of(paddr);
        pend        = 0;
      end
    end
  endtask

  // Scoreboard: a new delivery is any edge with if_valid high that was not stalled.
  always @(posedge clk) begin
    logic st, rs;
    exp_t e;
    st = stall;
    rs = rst_n;
    #1;
    if (rs && rst_n && if_valid && !st) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got pc=%h inst=%h, required no delivery", if_pc, if_inst);
      end else begin
        e = sb.pop_front();
        if (if_pc !== e.pc || if_inst !== e.inst) begin
          n_fail++;
          $display("FAIL sb_delivery: got pc=%h inst=%h, required pc=%h inst=%h",
                   if_pc, if_inst, e.pc, e.inst);
        end
      end
    end
  end

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", imem_req); end
    n_cmp++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", if_valid); end
    n_cmp++; if (if_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h want 0", if_pc); end
    n_cmp++; if (if_inst !== NOP) begin n_fail++; $display("FAIL rst_inst: got %h want %h", if_inst, NOP); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
    n_cmp++; if (flush_ifid !== 1'b0 || flush_idex !== 1'b0) begin n_fail++; $display("FAIL rst_flush0: got %b%b want 00", flush_ifid, flush_idex); end
    NextPCSrc = 1'b1;
    #1;
    n_cmp++; if (flush_ifid !== 1'b1 || flush_idex !== 1'b1) begin n_fail++; $display("FAIL rst_flush1: got %b%b want 11", flush_ifid, flush_idex); end
    NextPCSrc = 1'b0;
    #1;
  endtask

  task automatic test_sequential();
    sb.push_back(mk(32'h0));
    sb.push_back(mk(32'h4));
    rst_n = 1'b1;
    tick();
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL seq_first_req: got req=%b addr=%h want 1/0", imem_req, imem_addr); end
    tick();
    n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL seq_wait_req: got %b want 0", imem_req); end
    tick();
    n_cmp++; if (imem_addr !== 32'h4 || if_valid !== 1'b1) begin n_fail++; $display("FAIL seq_addr4: got addr=%h valid=%b want 4/1", imem_addr, if_valid); end
    tick();
    n_cmp++; if (if_valid !== 1'b0 || if_inst !== NOP) begin n_fail++; $display("FAIL seq_bubble: got valid=%b inst=%h want 0/%h", if_valid, if_inst, NOP); end
    tick();
    n_cmp++; if (imem_addr !== 32'h8) begin n_fail++; $display("FAIL seq_addr8: got %h want 8", imem_addr); end
  endtask

  task automatic test_stall_hold();
    stall = 1'b1;
    tick();
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h4) begin n_fail++; $display("FAIL stall_held: got valid=%b pc=%h want 1/4", if_valid, if_pc); end
    tick();
    n_cmp++; if (imem_req !== 1'b0 || if_pc !== 32'h4 || if_inst !== inst_of(32'h4)) begin n_fail++; $display("FAIL stall_hold_entry: got req=%b pc=%h inst=%h", imem_req, if_pc, if_inst); end
    tick();
    n_cmp++; if (imem_req !== 1'b0 || if_valid !== 1'b1) begin n_fail++; $display("FAIL stall_hold_stay: got req=%b valid=%b want 0/1", imem_req, if_valid); end
    stall = 1'b0;
    sb.push_back(mk(32'h8));
    tick();
    n_cmp++; if (if_pc !== 32'h8 || if_inst !== inst_of(32'h8)) begin n_fail++; $display("FAIL stall_release: got pc=%h inst=%h want 8/%h", if_pc, if_inst, inst_of(32'h8)); end
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin n_fail++; $display("FAIL stall_next_addr: got req=%b addr=%h want 1/c", imem_req, imem_addr); end
  endtask

  task automatic test_redirect_wait();
    sb.push_back(mk(32'hC));
    tick();
    tick();
    lat = 3;
    tick();
    NextPCSrc = 1'b1;
    br_target = 32'h0000_0103;
    #1;
    n_cmp++; if (flush_ifid !== 1'b1 || flush_idex !== 1'b1) begin n_fail++; $display("FAIL redir_flush: got %b%b want 11", flush_ifid, flush_idex); end
    tick();
    NextPCSrc = 1'b0;
    n_cmp++; if (if_valid !== 1'b0 || imem_req !== 1'b0) begin n_fail++; $display("FAIL redir_kill_wait: got valid=%b req=%b want 0/0", if_valid, imem_req); end
    tick();
    tick();
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || if_valid !== 1'b0) begin n_fail++; $display("FAIL redir_target: got req=%b addr=%h valid=%b want 1/100/0", imem_req, imem_addr, if_valid); end
    lat = 1;
    sb.push_back(mk(32'h100));
    tick();
    tick();
    n_cmp++; if (if_pc !== 32'h100 || imem_addr !== 32'h104) begin n_fail++; $display("FAIL redir_deliver: got pc=%h addr=%h want 100/104", if_pc, imem_addr); end
  endtask

  task automatic test_redirect_hold();
    stall = 1'b1;
    tick();
    tick();
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h100 || imem_req !== 1'b0) begin n_fail++; $display("FAIL hold_entry: got valid=%b pc=%h req=%b", if_valid, if_pc, imem_req); end
    NextPCSrc = 1'b1;
    br_target = 32'h0000_0200;
    tick();
    NextPCSrc = 1'b0;
    stall     = 1'b0;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin n_fail++; $display("FAIL hold_redir_addr: got req=%b addr=%h want 1/200", imem_req, imem_addr); end
    n_cmp++; if (if_valid !== 1'b0 || if_inst !== NOP) begin n_fail++; $display("FAIL hold_redir_kill: got valid=%b inst=%h want 0/%h", if_valid, if_inst, NOP); end
    sb.push_back(mk(32'h200));
    tick();
    tick();
    n_cmp++; if (if_pc !== 32'h200 || imem_addr !== 32'h204) begin n_fail++; $display("FAIL hold_after: got pc=%h addr=%h want 200/204", if_pc, imem_addr); end
  endtask

  task automatic test_wrap();
    NextPCSrc = 1'b1;
    br_target = 32'hFFFF_FFFF;
    tick();
    NextPCSrc = 1'b0;
    n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL wrap_accept_kill: got req=%b want 0", imem_req); end
    tick();
    n_cmp++; if (imem_addr !== 32'hFFFF_FFFC || if_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_target: got addr=%h valid=%b want fffffffc/0", imem_addr, if_valid); end
    sb.push_back(mk(32'hFFFF_FFFC));
    tick();
    tick();
    n_cmp++; if (imem_addr !== 32'h0 || if_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_next: got addr=%h pc=%h want 0/fffffffc", imem_addr, if_pc); end
  endtask

  task automatic test_back_to_back();
    imem_ready = 1'b0;
    NextPCSrc  = 1'b1;
    br_target  = 32'h0000_0300;
    tick();
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin n_fail++; $display("FAIL b2b_first: got req=%b addr=%h want 1/300", imem_req, imem_addr); end
    br_target = 32'h0000_0404;
    tick();
    NextPCSrc  = 1'b0;
    imem_ready = 1'b1;
    n_cmp++; if (imem_addr !== 32'h404) begin n_fail++; $display("FAIL b2b_last_wins: got %h want 404", imem_addr); end
    sb.push_back(mk(32'h404));
    tick();
    tick();
    n_cmp++; if (if_pc !== 32'h404 || imem_addr !== 32'h408) begin n_fail++; $display("FAIL b2b_deliver: got pc=%h addr=%h want 404/408", if_pc, imem_addr); end
  endtask

  task automatic test_reset_mid();
    lat = 3;
    tick();
    rst_n = 1'b0;
    #1;
    n_cmp++; if (imem_req !== 1'b0 || if_valid !== 1'b0 || if_pc !== 32'h0 || if_inst !== NOP || imem_addr !== 32'h0) begin
      n_fail++; $display("FAIL midrst_async: got req=%b valid=%b pc=%h inst=%h addr=%h", imem_req, if_valid, if_pc, if_inst, imem_addr);
    end
    tick();
    rst_n = 1'b1;
    tick();
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL midrst_req: got req=%b addr=%h want 1/0", imem_req, imem_addr); end
    lat = 1;
    sb.push_back(mk(32'h0));
    tick();
    tick();
    n_cmp++; if (if_pc !== 32'h0 || if_inst !== inst_of(32'h0) || imem_addr !== 32'h4) begin n_fail++; $display("FAIL midrst_first: got pc=%h inst=%h addr=%h want 0/a/4", if_pc, if_inst, imem_addr); end
  endtask

  initial begin
    rst_n       = 1'b0;
    NextPCSrc   = 1'b0;
    br_target   = 32'h0;
    stall       = 1'b0;
    imem_ready  = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    test_reset();
    test_sequential();
    test_stall_hold();
    test_redirect_wait();
    test_redirect_hold();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    tick();
    n_cmp++; if (sb.size() != 0) begin n_fail++; $display("FAIL sb_leftover: got %0d pending, want 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
